// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan multiplexer:
// segment table, off patterns, default timing and the display record.
package seg7_pkg;

  localparam int DEF_REFRESH_DIV  = 50000;
  localparam int DEF_BLANK_CYCLES = 4;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
  } disp_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Pure lookup into the shared table, no state.
module hex7seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with per-slot anode blanking and
// frame-coherent data update; outputs registered, 1 clock behind scan state.
// Define SEG7_BLANK_LEADING_ZERO_EN to blank leading zero digits.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [6:0]  segs7,
  output logic [3:0]  anodes,
  output logic        period,
  output logic [1:0]  digit_idx
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  disp_t         shadow;
  disp_t         disp;
  disp_t         incoming;
  logic          slot_end;
  logic          frame_end;

  assign incoming  = '{value: value, dp: dp, digit_en: digit_en};
  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= 2'd0;
      shadow <= '0;
      disp   <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx + 2'd1;
      if (load) shadow <= incoming;
      // Display only changes between frames; a same-edge load goes straight in.
      if (frame_end) disp <= load ? incoming : shadow;
    end
  end

  logic [3:0] nibble;
  logic [6:0] dec_segs;

  assign nibble = disp.value[{idx, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nibble (nibble),
    .segs   (dec_segs)
  );

  logic lz_blank;

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  // zero_from[k]: digit k and every digit above it are zero.
  logic [3:0] zero_from;
  assign zero_from[3] = (disp.value[15:12] == 4'd0);
  assign zero_from[2] = zero_from[3] && (disp.value[11:8] == 4'd0);
  assign zero_from[1] = zero_from[2] && (disp.value[7:4] == 4'd0);
  assign zero_from[0] = 1'b0;
  assign lz_blank = zero_from[idx] && !disp.dp[idx];
`else
  assign lz_blank = 1'b0;
`endif

  logic show;
  assign show = (cnt >= CNT_BLANK) && disp.digit_en[idx] && !lz_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      anodes    <= ANODE_OFF;
      segs7     <= SEG_OFF;
      period    <= 1'b1;
      digit_idx <= 2'd0;
    end else begin
      digit_idx <= idx;
      if (show) begin
        anodes <= ~(4'b0001 << idx);
        segs7  <= dec_segs;
        period <= ~disp.dp[idx];
      end else begin
        anodes <= ANODE_OFF;
        segs7  <= SEG_OFF;
        period <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Table-driven bench for seg7_scan_mux at REFRESH_DIV=8, BLANK_CYCLES=2;
// expected outputs per cycle come from per-vector slot tables via a scoreboard queue.
module tb_seg7_scan_mux;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        load;
  logic [6:0]  segs7;
  logic [3:0]  anodes;
  logic        period;
  logic [1:0]  digit_idx;

  seg7_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .dp        (dp),
    .digit_en  (digit_en),
    .load      (load),
    .segs7     (segs7),
    .anodes    (anodes),
    .period    (period),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  // Per-slot expectations during the lit part of a slot; index = slot.
  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0]      per;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       per;
    logic [1:0] idx;
  } out_t;

  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0][3:0] AN_NONE = {4'b1111, 4'b1111, 4'b1111, 4'b1111};
  localparam logic [6:0] OFF = 7'b1111111;

  vec_t tbl[9];
  out_t sb[$];
  int   pos;
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                              input logic [3:0][3:0] a, input logic [3:0][6:0] s,
                              input logic [3:0] p);
    vec_t r;
    r.value = v; r.dp = d; r.en = e; r.an = a; r.seg = s; r.per = p;
    return r;
  endfunction

  function automatic out_t expect_at(input int v, input int p);
    out_t o;
    int slot;
    int ph;
    slot  = (p / DIV) % 4;
    ph    = p % DIV;
    o.idx = 2'(slot);
    if (ph < BLK) begin
      o.an = 4'b1111; o.seg = OFF; o.per = 1'b1;
    end else begin
      o.an = tbl[v].an[slot]; o.seg = tbl[v].seg[slot]; o.per = tbl[v].per[slot];
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s (pos %0d): got %0h, expected %0h", name, pos, act, exp);
  endtask

  task automatic tick(input int v, input string tag);
    out_t e;
    if (reset) begin
      e.an = 4'b1111; e.seg = OFF; e.per = 1'b1; e.idx = 2'd0;
    end else begin
      e = expect_at(v, pos);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    pos  = reset ? 0 : pos + 1;
    load = 1'b0;
    e = sb.pop_front();
    chk({tag, "/anodes"},    int'(anodes),    int'(e.an));
    chk({tag, "/segs7"},     int'(segs7),     int'(e.seg));
    chk({tag, "/period"},    int'(period),    int'(e.per));
    chk({tag, "/digit_idx"}, int'(digit_idx), int'(e.idx));
  endtask

  task automatic run(input int v, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(v, tag);
  endtask

  task automatic run_to(input int v, input int ph, input string tag);
    int guard;
    guard = 0;
    while ((pos % FRAME) != ph && guard < 2 * FRAME) begin
      tick(v, tag);
      guard++;
    end
    if ((pos % FRAME) != ph) chk({tag, "/sync"}, pos % FRAME, ph);
  endtask

  task automatic drive(input int v);
    value    = tbl[v].value;
    dp       = tbl[v].dp;
    digit_en = tbl[v].en;
    load     = 1'b1;
  endtask

  initial begin
    int prev;
    tbl[0] = mk(16'h0000, 4'b0000, 4'b0000, AN_NONE, {OFF, OFF, OFF, OFF}, 4'b1111);
    tbl[1] = mk(16'h12AF, 4'b0100, 4'b1111, AN_ALL,
                {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1011);
    tbl[2] = mk(16'h9876, 4'b0001, 4'b0101, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {OFF, 7'b0000000, OFF, 7'b0000010}, 4'b1110);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    tbl[3] = mk(16'h0030, 4'b0000, 4'b1111, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {OFF, OFF, 7'b0110000, 7'b1000000}, 4'b1111);
    tbl[4] = mk(16'h0030, 4'b1000, 4'b1111, {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1000000, OFF, 7'b0110000, 7'b1000000}, 4'b0111);
`else
    tbl[3] = mk(16'h0030, 4'b0000, 4'b1111, AN_ALL,
                {7'b1000000, 7'b1000000, 7'b0110000, 7'b1000000}, 4'b1111);
    tbl[4] = mk(16'h0030, 4'b1000, 4'b1111, AN_ALL,
                {7'b1000000, 7'b1000000, 7'b0110000, 7'b1000000}, 4'b0111);
`endif
    tbl[5] = mk(16'hBCDE, 4'b0000, 4'b1111, AN_ALL,
                {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}, 4'b1111);
    tbl[6] = mk(16'h4570, 4'b1010, 4'b1111, AN_ALL,
                {7'b0011001, 7'b0010010, 7'b1111000, 7'b1000000}, 4'b0101);
    tbl[7] = mk(16'h2222, 4'b0000, 4'b1111, AN_ALL,
                {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'b1111);
    tbl[8] = mk(16'h1111, 4'b0000, 4'b1111, AN_ALL,
                {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}, 4'b1111);

    reset = 1'b1; load = 1'b0; value = '0; dp = '0; digit_en = '0;
    pos = 0;
    run(0, 3, "reset");
    reset = 1'b0;
    run(0, 40, "idle_scan");

    // Load mid-frame (slot 1): rest of frame shows old data, next frame the new.
    prev = 0;
    for (int v = 1; v <= 6; v++) begin
      run_to(prev, DIV, "pre_load");
      drive(v);
      tick(prev, "load_edge");
      run_to(prev, 0, "old_frame");
      run(v, FRAME, $sformatf("vec%0d", v));
      prev = v;
    end

    // Two loads inside one frame: only the later one ever appears.
    run_to(6, 2 * DIV + 3, "pre_1111");
    drive(8);
    tick(6, "load_1111");
    run_to(6, 3 * DIV + 2, "pre_2222");
    drive(7);
    tick(6, "load_2222");
    run_to(6, 0, "keep_old");
    run(7, FRAME, "only_2222");

    // Load on the frame-wrap edge is displayed from slot 0 of the new frame.
    run_to(7, FRAME - 1, "pre_wrap");
    drive(8);
    tick(7, "wrap_load");
    run(8, FRAME, "bypass");

    // Reset mid-slot 2 overrides a simultaneous load; scan restarts blank.
    run_to(8, 2 * DIV + 3, "pre_reset");
    reset = 1'b1;
    drive(1);
    tick(8, "mid_reset");
    reset = 1'b0;
    run(0, 2 * FRAME, "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
